// File: rtl/bit_count_ctrl.sv
// rtl/bit_count_ctrl.sv - control FSM driving an 8-bit ones counter (clear/inc pulses)
// Optional BIT_COUNT_EARLY_EXIT_EN: leave SHIFT as soon as no '1' bits remain.
module bit_count_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             clear_counter,
  output logic             inc_counter,
  output logic             done
);

  localparam int RW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             last_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    rem_d      = rem_q;
    last_shift = (rem_q == RW'(1));
`ifdef BIT_COUNT_EARLY_EXIT_EN
    if (shreg_q == '0) last_shift = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = data_in;
          rem_d   = RW'(WIDTH);
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = SHIFT;
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        // Guard keeps the remaining count from wrapping below zero.
        if (rem_q != '0) rem_d = rem_q - RW'(1);
        if (last_shift) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready         = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign clear_counter = (state_q == CLEAR);
  assign inc_counter   = (state_q == SHIFT) && shreg_q[0];
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_bit_count_ctrl.sv
// tb/tb_bit_count_ctrl.sv - directed-vector bench for bit_count_ctrl with a ones-counter model
module tb_bit_count_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready, busy, clear_counter, inc_counter, done;
  logic [7:0] count = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] clr_tr, inc_tr, done_tr, rdy_tr, busy_tr;

  bit_count_ctrl #(.WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .data_in       (data_in),
    .ready         (ready),
    .busy          (busy),
    .clear_counter (clear_counter),
    .inc_counter   (inc_counter),
    .done          (done)
  );

  always #5 clk = ~clk;

  // The external counter this block drives
  always @(posedge clk) begin
    if (clear_counter)    count <= 8'h00;
    else if (inc_counter) count <= count + 8'h01;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bit c of each trace holds the output during cycle c; cycle 0 carries the first start.
  task automatic run(input logic [31:0] sv, input logic [31:0] rv,
                     input logic [7:0] d0, input logic [7:0] d1, input int ncyc);
    clr_tr = '0; inc_tr = '0; done_tr = '0; rdy_tr = '0; busy_tr = '0;
    for (int c = 0; c < ncyc; c++) begin
      clr_tr[c]  = clear_counter;
      inc_tr[c]  = inc_counter;
      done_tr[c] = done;
      rdy_tr[c]  = ready;
      busy_tr[c] = busy;
      start   = sv[c];
      reset   = rv[c];
      data_in = (c == 0) ? d0 : d1;
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic check_run(input string tag, input logic [31:0] e_clr, input logic [31:0] e_inc,
                           input logic [31:0] e_done, input logic [31:0] e_rdy, input logic [7:0] e_cnt);
    chk({tag, ".clear"}, clr_tr, e_clr);
    chk({tag, ".inc"},   inc_tr, e_inc);
    chk({tag, ".done"},  done_tr, e_done);
    chk({tag, ".ready"}, rdy_tr, e_rdy);
    chk({tag, ".busy"},  busy_tr, ~e_rdy);
    chk({tag, ".count"}, {24'h0, count}, {24'h0, e_cnt});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.outs", {27'h0, ready, busy, clear_counter, inc_counter, done}, 32'h10);

    run(32'h1, 32'h0, 8'hA5, 8'hA5, 32);
`ifdef BIT_COUNT_EARLY_EXIT_EN
    check_run("a5", 32'h2, 32'h294, 32'h400, 32'hFFFF_F801, 8'd4);
`else
    check_run("a5", 32'h2, 32'h294, 32'h400, 32'hFFFF_F801, 8'd4);
`endif

    run(32'h1, 32'h0, 8'hFF, 8'hFF, 32);
    check_run("ff", 32'h2, 32'h3FC, 32'h400, 32'hFFFF_F801, 8'd8);

    run(32'h1, 32'h0, 8'h00, 8'h00, 32);
`ifdef BIT_COUNT_EARLY_EXIT_EN
    check_run("zero", 32'h2, 32'h0, 32'h8, 32'hFFFF_FFF1, 8'd0);
`else
    check_run("zero", 32'h2, 32'h0, 32'h400, 32'hFFFF_F801, 8'd0);
`endif

    // Second start with 0xFF lands in SHIFT (cycle 3) and must be ignored
    run(32'h9, 32'h0, 8'h01, 8'hFF, 32);
`ifdef BIT_COUNT_EARLY_EXIT_EN
    check_run("ign", 32'h2, 32'h4, 32'h10, 32'hFFFF_FFE1, 8'd1);
`else
    check_run("ign", 32'h2, 32'h4, 32'h400, 32'hFFFF_F801, 8'd1);
`endif

    run(32'h1, 32'h20, 8'hFF, 8'hFF, 32);
    check_run("rst_mid", 32'h2, 32'h3C, 32'h0, 32'hFFFF_FFC1, 8'd4);

    run(32'h1, 32'h0, 8'hA5, 8'hA5, 32);
    check_run("after_rst", 32'h2, 32'h294, 32'h400, 32'hFFFF_F801, 8'd4);

    run(32'hFFF, 32'h0, 8'h03, 8'h0F, 32);
`ifdef BIT_COUNT_EARLY_EXIT_EN
    check_run("b2b", 32'h82, 32'hF0C, 32'h2020, 32'hFFFF_C041, 8'd4);
`else
    check_run("b2b", 32'h1002, 32'h1E00C, 32'h20_0400, 32'hFFC0_0801, 8'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
